// File: rtl/alk_shfseq.sv
// alk_shfseq: shift-sequence controller for the ALU/Q shifter pair.
// Selects the ALU and Q shift-in bits from a latched mode and direction,
// counts shift steps gated by advance_h, and pulses done_h for one cycle.
// Optional feature macro: ALKSHFSEQ_PSLC_EN (rotate through PSL.C on the last step).
module alk_shfseq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_l,
    input  logic             start_h,
    input  logic [2:0]       mode_h,
    input  logic             dir_left_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic             advance_h,
    input  logic             abort_h,
    input  logic             alu_sout_shl_h,
    input  logic             alu_sout_shr_h,
    input  logic             q_sout_shl_h,
    input  logic             q_sout_shr_h,
    input  logic             c32_in_h,
    input  logic             pslc_flag_h,
    input  logic [WIDTH-1:0] wbus_h,
    output logic             alu_sin_h,
    output logic             q_sin_h,
    output logic             busy_h,
    output logic             done_h,
    output logic             loopf_h,
    output logic             aluso_h
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] M_FORCE0 = 3'd0;
    localparam logic [2:0] M_FORCE1 = 3'd1;
    localparam logic [2:0] M_ROT    = 3'd2;
    localparam logic [2:0] M_DSHF   = 3'd3;
    localparam logic [2:0] M_MUL    = 3'd4;
    localparam logic [2:0] M_DIV    = 3'd5;
    localparam logic [2:0] M_DIVD   = 3'd6;
    localparam logic [2:0] M_WB     = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic [2:0]       mode_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt;
    logic             loopf_q;
    logic             aluso_q;

    // Only the WB source bit of the W bus is consumed; pslc_flag_h is only
    // consumed when the rotate-through-carry feature is built in.
    logic unused_inputs;
    assign unused_inputs = ^{wbus_h, pslc_flag_h};

    // Sequencer state: mode/dir/count latch on start, step on advance, abort wins.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            state   <= S_IDLE;
            mode_q  <= 3'd0;
            dir_q   <= 1'b0;
            cnt     <= '0;
            loopf_q <= 1'b0;
            aluso_q <= 1'b0;
        end else if (abort_h) begin
            state   <= S_IDLE;
            loopf_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_h) begin
                        mode_q  <= mode_h;
                        dir_q   <= dir_left_h;
                        cnt     <= count_h;
                        loopf_q <= 1'b0;
                        aluso_q <= 1'b0;
                        state   <= (count_h != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    // cnt is never 0 here, so the decrement cannot wrap.
                    if (advance_h) begin
                        cnt     <= cnt - CNT_ONE;
                        loopf_q <= 1'b1;
                        aluso_q <= dir_q ? alu_sout_shl_h : alu_sout_shr_h;
                        if (cnt == CNT_ONE) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Shift-in selection: live only in RUN, forced low in every other state.
    always_comb begin
        alu_sin_h = 1'b0;
        q_sin_h   = 1'b0;
        if (state == S_RUN) begin
            case (mode_q)
                M_FORCE0: begin
                    alu_sin_h = 1'b0;
                    q_sin_h   = 1'b0;
                end
                M_FORCE1: begin
                    alu_sin_h = 1'b1;
                    q_sin_h   = 1'b0;
                end
                M_ROT: begin
                    alu_sin_h = dir_q ? alu_sout_shl_h : alu_sout_shr_h;
                    q_sin_h   = dir_q ? q_sout_shl_h   : q_sout_shr_h;
                end
                M_DSHF: begin
                    alu_sin_h = dir_q ? q_sout_shl_h : 1'b0;
                    q_sin_h   = dir_q ? 1'b0         : alu_sout_shr_h;
                end
                M_MUL: begin
                    alu_sin_h = c32_in_h & loopf_q;
                    q_sin_h   = alu_sout_shr_h;
                end
                M_DIV: begin
                    alu_sin_h = q_sout_shl_h;
                    q_sin_h   = c32_in_h;
                end
                M_DIVD: begin
                    alu_sin_h = aluso_q;
                    q_sin_h   = c32_in_h;
                end
                M_WB: begin
                    alu_sin_h = wbus_h[WIDTH-2];
                    q_sin_h   = wbus_h[WIDTH-2];
                end
                default: begin
                    alu_sin_h = 1'b0;
                    q_sin_h   = 1'b0;
                end
            endcase
`ifdef ALKSHFSEQ_PSLC_EN
            // Last rotate step pulls the carry flag in: rotate through carry.
            if (mode_q == M_ROT && cnt == CNT_ONE) begin
                alu_sin_h = pslc_flag_h;
            end
`endif
        end
    end

    // Status outputs decoded from state and the sequence flags.
    always_comb begin
        busy_h  = (state == S_RUN);
        done_h  = (state == S_DONE);
        loopf_h = loopf_q;
        aluso_h = aluso_q;
    end

endmodule

// File: tb/tb_alk_shfseq.sv
// Directed bench for alk_shfseq: a mode-decode vector table plus hand-written
// multi-cycle sequences (rotate, multiply, stall, zero count, abort, DIVD, reset).
module tb_alk_shfseq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk_h = 1'b0;
    logic             reset_l;
    logic             start_h;
    logic [2:0]       mode_h;
    logic             dir_left_h;
    logic [CNT_W-1:0] count_h;
    logic             advance_h;
    logic             abort_h;
    logic             alu_sout_shl_h, alu_sout_shr_h, q_sout_shl_h, q_sout_shr_h;
    logic             c32_in_h;
    logic             pslc_flag_h;
    logic [WIDTH-1:0] wbus_h;
    logic             alu_sin_h, q_sin_h, busy_h, done_h, loopf_h, aluso_h;

    int nvec = 0;
    int nerr = 0;

    alk_shfseq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_h          (clk_h),
        .reset_l        (reset_l),
        .start_h        (start_h),
        .mode_h         (mode_h),
        .dir_left_h     (dir_left_h),
        .count_h        (count_h),
        .advance_h      (advance_h),
        .abort_h        (abort_h),
        .alu_sout_shl_h (alu_sout_shl_h),
        .alu_sout_shr_h (alu_sout_shr_h),
        .q_sout_shl_h   (q_sout_shl_h),
        .q_sout_shr_h   (q_sout_shr_h),
        .c32_in_h       (c32_in_h),
        .pslc_flag_h    (pslc_flag_h),
        .wbus_h         (wbus_h),
        .alu_sin_h      (alu_sin_h),
        .q_sin_h        (q_sin_h),
        .busy_h         (busy_h),
        .done_h         (done_h),
        .loopf_h        (loopf_h),
        .aluso_h        (aluso_h)
    );

    always #5 clk_h = ~clk_h;

    typedef struct {
        logic [2:0] mode;
        logic       dir;
        logic       shl, shr, qshl, qshr, c32, wb;
        logic       exp_alu, exp_q;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next cycle: inputs driven after this are sampled at the next edge.
    task automatic cyc();
        @(posedge clk_h);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr_inputs();
        start_h = 0; mode_h = 0; dir_left_h = 0; count_h = 0; advance_h = 0; abort_h = 0;
        alu_sout_shl_h = 0; alu_sout_shr_h = 0; q_sout_shl_h = 0; q_sout_shr_h = 0;
        c32_in_h = 0; pslc_flag_h = 0; wbus_h = '0;
    endtask

    // Called in an IDLE cycle: request a start, then move into the first post-start cycle.
    task automatic do_start(input logic [2:0] m, input logic d, input int c);
        start_h = 1; mode_h = m; dir_left_h = d; count_h = CNT_W'(c);
        cyc();
        start_h = 0;
    endtask

    initial begin
        // mode, dir, shl, shr, qshl, qshr, c32, wb, exp_alu, exp_q
        tbl[0]  = '{3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        clr_inputs();

        // Reset: outputs low while held, and low/idle after release.
        reset_l = 0;
        start_h = 1; mode_h = 3'd1; count_h = 6'd3; advance_h = 1;
        cyc(); cyc();
        chk("rst_hold_busy", busy_h, 0);
        chk("rst_hold_outs", {alu_sin_h, q_sin_h, done_h, loopf_h, aluso_h}, 0);
        clr_inputs();
        reset_l = 1;
        cyc(); settle();
        chk("idle_busy", busy_h, 0);
        chk("idle_outs", {alu_sin_h, q_sin_h, done_h, loopf_h, aluso_h}, 0);

        // Mode decode table, checked in the first RUN cycle, each run ended by abort.
        for (int i = 0; i < 11; i++) begin
            do_start(tbl[i].mode, tbl[i].dir, 5);
            alu_sout_shl_h = tbl[i].shl; alu_sout_shr_h = tbl[i].shr;
            q_sout_shl_h = tbl[i].qshl; q_sout_shr_h = tbl[i].qshr;
            c32_in_h = tbl[i].c32;
            wbus_h = tbl[i].wb ? 32'h4000_0000 : 32'hBFFF_FFFF;
            settle();
            chk($sformatf("tbl%0d_busy", i), busy_h, 1);
            chk($sformatf("tbl%0d_alu_sin", i), alu_sin_h, tbl[i].exp_alu);
            chk($sformatf("tbl%0d_q_sin", i), q_sin_h, tbl[i].exp_q);
            abort_h = 1;
            cyc();
            abort_h = 0;
            settle();
            chk($sformatf("tbl%0d_abort_idle", i), {busy_h, done_h, alu_sin_h, q_sin_h}, 0);
        end
        clr_inputs();
        cyc();

        // Rotate left, count 4, advance held high.
        pslc_flag_h = 0;
        advance_h = 1; alu_sout_shl_h = 1;
        do_start(3'd2, 1'b1, 4);
        for (int k = 1; k <= 4; k++) begin
            settle();
            chk($sformatf("rot_busy_c%0d", k), busy_h, 1);
`ifdef ALKSHFSEQ_PSLC_EN
            chk($sformatf("rot_alu_sin_c%0d", k), alu_sin_h, (k == 4) ? 0 : 1);
`else
            chk($sformatf("rot_alu_sin_c%0d", k), alu_sin_h, 1);
`endif
            cyc();
        end
        settle();
        chk("rot_done", {done_h, busy_h, alu_sin_h, q_sin_h}, 4'b1000);
        cyc(); settle();
        chk("rot_after_done", {done_h, busy_h}, 0);
        clr_inputs();

        // Multiply, count 3, c32=1: loopf gates the ALU shift-in.
        advance_h = 1; c32_in_h = 1;
        do_start(3'd4, 1'b0, 3);
        settle();
        chk("mul_c1_alu_sin", alu_sin_h, 0);
        chk("mul_c1_loopf", loopf_h, 0);
        cyc(); settle();
        chk("mul_c2_alu_sin", alu_sin_h, 1);
        chk("mul_c2_loopf", loopf_h, 1);
        cyc(); settle();
        chk("mul_c3_alu_sin", alu_sin_h, 1);
        cyc(); settle();
        chk("mul_done", done_h, 1);
        cyc(); settle();
        chk("mul_loopf_hold_idle", loopf_h, 1);
        clr_inputs();

        // Stall: count 2, advance pattern 1,0,0,1; loopf cleared by the new start.
        begin
            logic [3:0] pat;
            pat = 4'b1001;
            do_start(3'd0, 1'b0, 2);
            for (int k = 0; k < 4; k++) begin
                advance_h = pat[3-k];
                settle();
                chk($sformatf("stall_busy_c%0d", k + 1), busy_h, 1);
                if (k == 0) chk("stall_loopf_cleared", loopf_h, 0);
                cyc();
            end
            advance_h = 0;
            settle();
            chk("stall_done", {done_h, busy_h}, 2'b10);
        end
        cyc();

        // Zero count: DONE directly; start held through DONE is ignored, then accepted in IDLE.
        do_start(3'd1, 1'b0, 0);
        start_h = 1; count_h = 0;
        settle();
        chk("zero_done", {done_h, busy_h}, 2'b10);
        cyc(); settle();
        chk("zero_idle_after", {done_h, busy_h}, 0);
        cyc(); start_h = 0; settle();
        chk("zero_restart_done", done_h, 1);
        cyc();

        // Abort in the second RUN cycle: back to IDLE, loopf cleared, no done.
        advance_h = 1;
        do_start(3'd1, 1'b0, 5);
        cyc();
        abort_h = 1; settle();
        chk("abort_c2_busy", busy_h, 1);
        chk("abort_c2_loopf", loopf_h, 1);
        cyc(); abort_h = 0; settle();
        chk("abort_idle", {busy_h, done_h, loopf_h}, 0);
        cyc(); settle();
        chk("abort_no_done", done_h, 0);
        clr_inputs();

        // DIVD left, count 2: ALU shift-in follows the previous step's captured bit.
        advance_h = 1; alu_sout_shl_h = 1; c32_in_h = 1;
        do_start(3'd6, 1'b1, 2);
        settle();
        chk("divd_c1_alu_sin", alu_sin_h, 0);
        chk("divd_c1_q_sin", q_sin_h, 1);
        cyc(); c32_in_h = 0; settle();
        chk("divd_c2_alu_sin", alu_sin_h, 1);
        chk("divd_c2_q_sin", q_sin_h, 0);
        chk("divd_c2_aluso", aluso_h, 1);
        cyc(); settle();
        chk("divd_done", done_h, 1);
        clr_inputs();
        cyc();

        // Maximum count (all ones) runs the full 63 steps with no wrap.
        begin
            int busy_cycles;
            busy_cycles = 0;
            advance_h = 1;
            do_start(3'd0, 1'b0, 63);
            settle();
            while (busy_h && busy_cycles < 100) begin
                busy_cycles++;
                cyc(); settle();
            end
            chk("maxcnt_busy_cycles", busy_cycles, 63);
            chk("maxcnt_done", done_h, 1);
            clr_inputs();
            cyc();
        end

        // Asynchronous reset mid-sequence: immediate idle, no done afterwards.
        advance_h = 1;
        do_start(3'd1, 1'b0, 3);
        settle();
        reset_l = 0;
        settle();
        chk("midrst_outs", {busy_h, done_h, alu_sin_h, q_sin_h, loopf_h, aluso_h}, 0);
        cyc();
        reset_l = 1;
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 5; k++) begin
                cyc(); settle();
                if (done_h) seen_done++;
            end
            chk("midrst_no_done", seen_done, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
